// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 8-digit common-anode 7-segment scan driver
// Steps one digit per scan-tick rise, showing a per-frame snapshot with an anode guard gap.
module seg7_scan_driver #(
  parameter int GUARD = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        ScanTick,
  input  logic [31:0] Value,
  input  logic [7:0]  Blank,
  input  logic [7:0]  DpMask,
  output logic [7:0]  An,
  output logic [6:0]  Seg,
  output logic        Dp
);

  localparam logic [3:0] GuardInit = 4'(GUARD);

  // Active-low cathode patterns, bit order g,f,e,d,c,b,a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic        prev_tick_q, prev_tick_d;
  logic [2:0]  digit_idx_q, digit_idx_d;
  logic [3:0]  guard_cnt_q, guard_cnt_d;
  logic [31:0] snap_val_q, snap_val_d;
  logic [7:0]  snap_blank_q, snap_blank_d;
  logic [7:0]  snap_dp_q, snap_dp_d;
  logic        load_pending_q, load_pending_d;
  logic [7:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        dp_q, dp_d;

  logic        rise;
  logic        cur_blank;
  logic [3:0]  cur_nib;

  assign rise      = ScanTick & ~prev_tick_q;
  assign cur_blank = snap_blank_q[digit_idx_q];
  assign cur_nib   = snap_val_q[{digit_idx_q, 2'b00} +: 4];

  always_comb begin
    prev_tick_d    = ScanTick;
    digit_idx_d    = digit_idx_q;
    guard_cnt_d    = guard_cnt_q;
    snap_val_d     = snap_val_q;
    snap_blank_d   = snap_blank_q;
    snap_dp_d      = snap_dp_q;
    load_pending_d = load_pending_q;
    an_d           = 8'hFF;

    // The post-reset load wins over a coincident wrap; both take the live inputs.
    if (load_pending_q || (rise && digit_idx_q == 3'd7)) begin
      snap_val_d     = Value;
      snap_blank_d   = Blank;
      snap_dp_d      = DpMask;
      load_pending_d = 1'b0;
    end

    if (rise) begin
      digit_idx_d = digit_idx_q + 3'd1;
    end

    // The load cycle opens a full guard so digit 0 gets settled cathodes first.
    if (rise || load_pending_q) begin
      guard_cnt_d = GuardInit;
    end else if (guard_cnt_q != 4'd0) begin
      guard_cnt_d = guard_cnt_q - 4'd1;
    end else if (!cur_blank) begin
      an_d = ~(8'h01 << digit_idx_q);
    end
  end

  always_comb begin
    seg_d = 7'h7F;
    dp_d  = 1'b1;
    if (!cur_blank) begin
      seg_d = hex_to_seg(cur_nib);
      dp_d  = ~snap_dp_q[digit_idx_q];
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      prev_tick_q    <= 1'b0;
      digit_idx_q    <= 3'd0;
      guard_cnt_q    <= GuardInit;
      snap_val_q     <= 32'h0;
      snap_blank_q   <= 8'h00;
      snap_dp_q      <= 8'h00;
      load_pending_q <= 1'b1;
      an_q           <= 8'hFF;
      seg_q          <= 7'h7F;
      dp_q           <= 1'b1;
    end else begin
      prev_tick_q    <= prev_tick_d;
      digit_idx_q    <= digit_idx_d;
      guard_cnt_q    <= guard_cnt_d;
      snap_val_q     <= snap_val_d;
      snap_blank_q   <= snap_blank_d;
      snap_dp_q      <= snap_dp_d;
      load_pending_q <= load_pending_d;
      an_q           <= an_d;
      seg_q          <= seg_d;
      dp_q           <= dp_d;
    end
  end

  assign An  = an_q;
  assign Seg = seg_q;
  assign Dp  = dp_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - testbench for seg7_scan_driver
// Directed scenarios plus randomized scanning against a timestamp-based reference model.
module tb_seg7_scan_driver;
  localparam int GUARD = 4;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ScanTick;
  logic [31:0] Value;
  logic [7:0]  Blank;
  logic [7:0]  DpMask;
  logic [7:0]  An;
  logic [6:0]  Seg;
  logic        Dp;

  int checks = 0;
  int errors = 0;

  seg7_scan_driver #(.GUARD(GUARD)) dut (
    .Clk(Clk), .Rst(Rst), .ScanTick(ScanTick), .Value(Value),
    .Blank(Blank), .DpMask(DpMask), .An(An), .Seg(Seg), .Dp(Dp)
  );

  always #5 Clk = ~Clk;

  logic [6:0] seg_tab [16];

  // Model: frame snapshot plus the edge at which the current guard started.
  int          m_edge = 0;
  int          m_gstart = 0;
  int          m_digit;
  bit          m_pend;
  bit          m_prev;
  logic [31:0] m_val;
  logic [7:0]  m_blank;
  logic [7:0]  m_dpm;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  task automatic model_reset();
    m_pend = 1; m_prev = 0; m_digit = 0;
    m_val = 32'h0; m_blank = 8'h00; m_dpm = 8'h00;
    m_an = 8'hFF; m_seg = 7'h7F; m_dp = 1'b1;
    m_gstart = m_edge;
  endtask

  task automatic tick();
    logic        st, r;
    logic [31:0] v;
    logic [7:0]  b, d;
    bit          rs;
    logic [3:0]  nib;
    st = ScanTick; r = Rst; v = Value; b = Blank; d = DpMask;
    @(posedge Clk);
    m_edge++;
    if (!r) begin
      model_reset();
    end else begin
      rs  = st && !m_prev;
      nib = m_val[4*m_digit +: 4];
      if (m_blank[m_digit]) begin
        m_seg = 7'h7F; m_dp = 1'b1;
      end else begin
        m_seg = seg_tab[nib]; m_dp = !m_dpm[m_digit];
      end
      if (m_pend || rs) begin
        m_an = 8'hFF; m_gstart = m_edge;
      end else if (m_edge >= m_gstart + GUARD + 1 && !m_blank[m_digit]) begin
        m_an = ~(8'h01 << m_digit);
      end else begin
        m_an = 8'hFF;
      end
      if (m_pend || (rs && m_digit == 7)) begin
        m_val = v; m_blank = b; m_dpm = d;
      end
      m_pend = 0;
      if (rs) m_digit = (m_digit + 1) % 8;
      m_prev = st;
    end
    #1;
  endtask

  task automatic do_reset(input logic [31:0] v, input logic [7:0] b, input logic [7:0] d);
    ScanTick = 1'b0; Value = v; Blank = b; DpMask = d;
    Rst = 1'b0;
    tick();
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    Rst = 1'b0; ScanTick = 1'($urandom_range(0, 1));
    Value = $urandom; Blank = 8'($urandom); DpMask = 8'($urandom);
    repeat (3) tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected ff", An); end
    checks++; if (Seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h expected 7f", Seg); end
    checks++; if (Dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b expected 1", Dp); end
    Value = 32'h0; Blank = 8'h00; DpMask = 8'h00; ScanTick = 1'b0; Rst = 1'b1;
    tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL release_an_r: got %h expected ff", An); end
    tick();
    checks++; if (Seg !== 7'h40) begin errors++; $display("FAIL release_seg_r1: got %h expected 40", Seg); end
    repeat (GUARD - 1) tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL release_an_r4: got %h expected ff", An); end
    tick();
    checks++; if (An !== 8'hFE) begin errors++; $display("FAIL release_an_r5: got %h expected fe", An); end
  endtask

  task automatic test_single_advance();
    do_reset(32'h8765_4321, 8'h00, 8'h00);
    repeat (GUARD + 3) tick();
    checks++; if (An !== 8'hFE || Seg !== 7'h79) begin errors++; $display("FAIL adv_digit0: got an=%h seg=%h expected fe 79", An, Seg); end
    ScanTick = 1'b1;
    tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL adv_an_k: got %h expected ff", An); end
    ScanTick = 1'b0;
    tick();
    checks++; if (Seg !== 7'h24) begin errors++; $display("FAIL adv_seg_k1: got %h expected 24", Seg); end
    repeat (GUARD - 1) tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL adv_an_k4: got %h expected ff", An); end
    tick();
    checks++; if (An !== 8'hFD) begin errors++; $display("FAIL adv_an_k5: got %h expected fd", An); end
  endtask

  task automatic test_frame_snapshot();
    logic [7:0] exp_an;
    for (int d = 2; d <= 3; d++) begin
      ScanTick = 1'b1; tick(); ScanTick = 1'b0;
      repeat (GUARD + 1) tick();
    end
    checks++; if (An !== 8'hF7 || Seg !== 7'h19) begin errors++; $display("FAIL snap_digit3: got an=%h seg=%h expected f7 19", An, Seg); end
    Value = 32'hFFFF_FFFF;
    for (int d = 4; d <= 7; d++) begin
      ScanTick = 1'b1; tick(); ScanTick = 1'b0;
      repeat (GUARD + 1) tick();
      exp_an = ~(8'h01 << d);
      checks++;
      if (An !== exp_an || Seg !== seg_tab[d + 1]) begin
        errors++; $display("FAIL snap_digit%0d: got an=%h seg=%h expected %h %h", d, An, Seg, exp_an, seg_tab[d + 1]);
      end
    end
    ScanTick = 1'b1; tick(); ScanTick = 1'b0;
    tick();
    checks++; if (Seg !== 7'h0E) begin errors++; $display("FAIL snap_wrap_seg: got %h expected 0e", Seg); end
    repeat (GUARD) tick();
    checks++; if (An !== 8'hFE) begin errors++; $display("FAIL snap_wrap_an: got %h expected fe", An); end
  endtask

  task automatic test_tick_during_guard();
    ScanTick = 1'b1; tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL guard_first_rise: got %h expected ff", An); end
    ScanTick = 1'b0; tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL guard_gap: got %h expected ff", An); end
    ScanTick = 1'b1; tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL guard_second_rise: got %h expected ff", An); end
    ScanTick = 1'b0;
    for (int i = 1; i <= GUARD; i++) begin
      tick();
      checks++; if (An !== 8'hFF) begin errors++; $display("FAIL guard_hold_%0d: got %h expected ff", i, An); end
    end
    tick();
    checks++; if (An !== 8'hFB || Seg !== 7'h0E) begin errors++; $display("FAIL guard_digit2: got an=%h seg=%h expected fb 0e", An, Seg); end
  endtask

  task automatic test_blank_dp();
    do_reset($urandom, 8'h02, 8'h01);
    repeat (GUARD + 2) tick();
    checks++; if (An !== 8'hFE || Dp !== 1'b0) begin errors++; $display("FAIL bdp_digit0: got an=%h dp=%b expected fe 0", An, Dp); end
    ScanTick = 1'b1; tick(); ScanTick = 1'b0;
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL bdp_rise_an: got %h expected ff", An); end
    for (int i = 1; i <= 2 * GUARD + 4; i++) begin
      tick();
      checks++;
      if (An !== 8'hFF || Seg !== 7'h7F || Dp !== 1'b1) begin
        errors++; $display("FAIL bdp_blank_%0d: got an=%h seg=%h dp=%b expected ff 7f 1", i, An, Seg, Dp);
      end
    end
    ScanTick = 1'b1; tick(); ScanTick = 1'b0;
    repeat (GUARD + 1) tick();
    checks++; if (An !== 8'hFB) begin errors++; $display("FAIL bdp_digit2: got %h expected fb", An); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] v;
    Rst = 1'b0;
    #1;
    checks++;
    if (An !== 8'hFF || Seg !== 7'h7F || Dp !== 1'b1) begin
      errors++; $display("FAIL midrst_async: got an=%h seg=%h dp=%b expected ff 7f 1", An, Seg, Dp);
    end
    model_reset();
    v = $urandom; Value = v; Blank = 8'h00; DpMask = 8'h00;
    tick();
    Rst = 1'b1;
    tick();
    tick();
    checks++; if (Seg !== seg_tab[v[3:0]]) begin errors++; $display("FAIL midrst_seg_r1: got %h expected %h", Seg, seg_tab[v[3:0]]); end
    repeat (GUARD - 1) tick();
    checks++; if (An !== 8'hFF) begin errors++; $display("FAIL midrst_an_r4: got %h expected ff", An); end
    tick();
    checks++; if (An !== 8'hFE) begin errors++; $display("FAIL midrst_an_r5: got %h expected fe", An); end
  endtask

  task automatic test_random();
    do_reset($urandom, 8'($urandom), 8'($urandom));
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 9) == 0) ScanTick = ~ScanTick;
      if ($urandom_range(0, 15) == 0) begin
        Value = $urandom; Blank = 8'($urandom_range(0, 3) == 0 ? $urandom : 0); DpMask = 8'($urandom);
      end
      Rst = ($urandom_range(0, 799) == 0) ? 1'b0 : 1'b1;
      tick();
      checks++;
      if (An !== m_an || Seg !== m_seg || Dp !== m_dp) begin
        errors++; $display("FAIL rand_cycle_%0d: got an=%h seg=%h dp=%b expected %h %h %b", i, An, Seg, Dp, m_an, m_seg, m_dp);
      end
    end
    Rst = 1'b1;
  endtask

  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    model_reset();
    test_reset();
    test_single_advance();
    test_frame_snapshot();
    test_tick_during_guard();
    test_blank_dp();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Time-multiplexed driver for the board's 8-digit, common-anode seven-segment display. Sits directly downstream of the clock divider: it samples the divider's slow output as a scan tick in the fast board-clock domain, steps one digit per tick, and drives anode/cathode pins from a frame-consistent snapshot of a 32-bit display value, such as a PC or register readout. Anodes are held off for a guard interval on every digit change to suppress ghosting.

## Interface
- GUARD, default 4: cycles all anodes stay off after each digit advance. Legal range 1..15.
- Clk  input  1  board clock; all state updates on its rising edge.
- Rst  input  1  reset, asynchronous and active-low (0 = reset).
- ScanTick  input  1  slow level from the clock divider output, synchronous to Clk. Each 0→1 transition advances one digit.
- Value  input  32  hex value to show. Digit i shows Value[4i+3:4i]; digit 7 is leftmost.
- Blank  input  8  per-digit blank mask; 1 = digit dark.
- DpMask  input  8  per-digit decimal point; 1 = point lit.
- An  output  8  anode enables, active-low; at most one bit is 0.
- Seg  output  7  cathodes, active-low, Seg[6:0] = g,f,e,d,c,b,a.
- Dp  output  1  decimal-point cathode, active-low.

## Operation
- State:
  - PrevTick (1 b)
  - DigitIdx (3 b)
  - GuardCnt (4 b)
  - snapshot registers SnapVal (32 b), SnapBlank (8 b) and SnapDp (8 b)
  - LoadPending (1 b)
- Rise = ScanTick & ~PrevTick. PrevTick <= ScanTick every cycle.
- Reset values:
  - PrevTick=0, DigitIdx=0, GuardCnt=GUARD, LoadPending=1
  - all snapshot registers 0
  - An=8'hFF, Seg=7'h7F, Dp=1
- Snapshot:
  - Loads Value, Blank and DpMask in the first cycle after reset release, while LoadPending=1; that load clears LoadPending.
  - Thereafter loads on every Rise with DigitIdx==7, i.e. when the index wraps to 0.
  - Inputs changing mid-frame do not affect the current frame.
- Rise cycle:
  - DigitIdx <= DigitIdx+1 modulo 8 (7 wraps to 0).
  - GuardCnt <= GUARD; An <= 8'hFF.
- Non-Rise cycle:
  - GuardCnt≠0: GuardCnt <= GuardCnt−1; An <= 8'hFF.
  - GuardCnt==0: An <= ~(8'b1 << DigitIdx), unless SnapBlank[DigitIdx]=1, in which case An <= 8'hFF.
- Seg and Dp are registered every cycle from the current DigitIdx and snapshot:
  - SnapBlank[DigitIdx]=1: Seg=7'h7F, Dp=1.
  - Otherwise: Seg=hex(SnapVal nibble), Dp=~SnapDp[DigitIdx].
- Hex encoding (active-low, hex bytes):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- Rise while GuardCnt≠0: still advances DigitIdx and reloads GuardCnt; a partially elapsed guard never enables an anode.
- Rise on the same cycle as LoadPending: the LoadPending load takes priority and supplies the snapshot. DigitIdx still advances.

## Timing
- Rise is seen at edge k when ScanTick is 1 at edge k and was 0 at edge k−1.
- Edge k: DigitIdx, GuardCnt and An=FF update. Edge k+1: Seg/Dp reflect the new digit.
- Edge k+GUARD+1: the new anode bit goes low. Seg is therefore stable for GUARD cycles before the anode turns on.
- After reset release at edge r: snapshot loads at r.
  - Seg shows digit 0 of the loaded snapshot from edge r+1.
  - An=8'hFE from edge r+GUARD+1, unless digit 0 is blanked.
- Reset asserted mid-operation: all outputs take their reset values immediately (asynchronously), with no glitch to a lit anode.
- ScanTick held high gives no further advance; only a 0→1 transition counts.
- Minimum ScanTick period for full brightness exceeds 2·(GUARD+2) cycles. Faster ticks are legal but shorten each digit's on-time.

## Test plan
- Reset: hold Rst=0 with random inputs.
  - Required: An=FF, Seg=7F, Dp=1.
  - Release with Value=32'h0000_0000: Seg=40 at r+1, An=FE at r+5 (GUARD=4).
- Single advance: Value=32'h8765_4321, one ScanTick rise at edge k.
  - Required: An=FF at k; Seg=24 ('2') at k+1; An=FD at k+5.
- Frame snapshot: change Value to 32'hFFFF_FFFF after digit 3 is lit.
  - Required: digits 4–7 still show 5,6,7,8.
  - The rise that wraps 7→0 loads the new value; digit 0 then shows Seg=0E.
- Tick during guard: a second rise 2 cycles after the first.
  - Required: An stays FF; DigitIdx advances twice; the anode of the second digit enables 5 cycles after the second rise.
- Blank/Dp: Blank=8'h02, DpMask=8'h01.
  - Required: digit 0 gives Dp=0; digit 1 keeps An=FF, Seg=7F, Dp=1 through its whole slot.
- Mid-operation reset: assert Rst=0 while An=FB.
  - Required: An=FF, Seg=7F, Dp=1 in the same cycle.
  - After release, the scan restarts at digit 0 with a fresh snapshot.
